// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM state, read owner and
// the request bundle that is multiplexed onto the RAM port.
package dmem_arb_pkg;

    typedef enum logic {
        S_ARB   = 1'b0,
        S_HLOCK = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_rsp.sv
// Read-return tracker: remembers who issued the last accepted read and steers
// the RAM's registered read data back to that requester one cycle later.
module dmem_arb_rsp
    import dmem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        rd_acc,
    input  owner_e      acc_owner,
    input  logic [31:0] dmem_rdata,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        h_rvalid,
    output logic [31:0] h_rdata
);

    logic   rd_pend;
    owner_e rd_owner;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWN_CORE;
        end else begin
            rd_pend <= rd_acc;
            if (rd_acc) begin
                rd_owner <= acc_owner;
            end
        end
    end

    // Data is broadcast; only the rvalid qualifies which requester consumes it.
    assign c_rvalid = rd_pend && (rd_owner == OWN_CORE);
    assign h_rvalid = rd_pend && (rd_owner == OWN_HOST);
    assign c_rdata  = dmem_rdata;
    assign h_rdata  = dmem_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single RAM data port between the core LSU and the host loader:
// core priority, host starvation guard and a bounded host bus-lock.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_LOCK     = 16,
    parameter int CNT_W        = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_be,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    input  logic        h_req,
    input  logic        h_we,
    input  logic [31:0] h_addr,
    input  logic [31:0] h_wdata,
    input  logic [3:0]  h_be,
    input  logic        h_lock,
    output logic        h_gnt,
    output logic        h_rvalid,
    output logic [31:0] h_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata
);

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(MAX_LOCK - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] lock_cnt;
    logic             force_rel;
    logic             host_pri;
    logic             lock_max;
    mem_req_t         c_bus, h_bus, m_bus;

    assign lock_max = (lock_cnt == LOCK_LAST);

    always_comb begin
        c_gnt    = 1'b0;
        h_gnt    = 1'b0;
        host_pri = 1'b0;
        state_d  = state_q;
        case (state_q)
            S_ARB: begin
                // The cycle right after a forced release belongs to the core.
                host_pri = h_req && (starve_cnt == STARVE_MAX) && !force_rel;
                c_gnt    = c_req && !host_pri;
                h_gnt    = h_req && !c_gnt;
                if (h_gnt && h_lock) begin
                    state_d = S_HLOCK;
                end
            end
            S_HLOCK: begin
                h_gnt = h_req;
                if (!h_lock || lock_max) begin
                    state_d = S_ARB;
                end
            end
            default: state_d = S_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_ARB;
            starve_cnt <= '0;
            lock_cnt   <= '0;
            force_rel  <= 1'b0;
        end else begin
            state_q   <= state_d;
            force_rel <= (state_q == S_HLOCK) && h_lock && lock_max;
            if (h_gnt) begin
                starve_cnt <= '0;
            end else if (h_req && (starve_cnt < STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (state_q == S_HLOCK) begin
                lock_cnt <= lock_cnt + 1'b1;
            end else if (state_d == S_HLOCK) begin
                lock_cnt <= '0;
            end
        end
    end

    assign c_bus = '{we: c_we, addr: c_addr, wdata: c_wdata, be: c_be};
    assign h_bus = '{we: h_we, addr: h_addr, wdata: h_wdata, be: h_be};
    assign m_bus = h_gnt ? h_bus : c_bus;

    assign dmem_req   = c_gnt | h_gnt;
    assign dmem_we    = m_bus.we;
    assign dmem_addr  = m_bus.addr;
    assign dmem_wdata = m_bus.wdata;
    assign dmem_be    = m_bus.be;

    dmem_arb_rsp u_rsp (
        .clk        (clk),
        .rstn       (rstn),
        .rd_acc     (dmem_req && !m_bus.we),
        .acc_owner  (h_gnt ? OWN_HOST : OWN_CORE),
        .dmem_rdata (dmem_rdata),
        .c_rvalid   (c_rvalid),
        .c_rdata    (c_rdata),
        .h_rvalid   (h_rvalid),
        .h_rdata    (h_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural arbitration/memory model
// predicts grants and read returns; a negedge monitor checks the DUT.
module tb_dmem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int MAX_LOCK     = 16;

    logic        clk;
    logic        rstn;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [3:0]  c_be;
    logic        h_req, h_we, h_lock, h_gnt, h_rvalid;
    logic [31:0] h_addr, h_wdata, h_rdata;
    logic [3:0]  h_be;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_LOCK(MAX_LOCK), .CNT_W(5)) dut (
        .clk(clk), .rstn(rstn),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_be(h_be),
        .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM environment with a registered read port
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (dmem_req) begin
            if (dmem_we) begin
                for (int b = 0; b < 4; b++)
                    if (dmem_be[b]) ram[dmem_addr[9:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end else begin
                dmem_rdata <= ram[dmem_addr[9:2]];
            end
        end
    end

    typedef struct {
        int          cyc;
        bit          c;
        bit          h;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } gexp_t;

    typedef struct {
        int          cyc;
        bit          host;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] mmem [256];
    bit m_locked;
    int m_lock_cycles;
    int m_starve;
    bit m_after_force;
    bit last_c, last_h;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_locked      = 1'b0;
        m_lock_cycles = 0;
        m_starve      = 0;
        m_after_force = 1'b0;
        gq.delete();
        rq.delete();
    endtask

    // Predict this cycle from the current inputs, then advance one clock.
    task automatic cycle();
        gexp_t g;
        rexp_t r;
        bit eg_c, eg_h, host_turn, nf;
        logic [7:0] idx;
        if (m_locked) begin
            eg_c = 1'b0;
            eg_h = h_req;
        end else begin
            host_turn = h_req && (m_starve >= STARVE_LIMIT) && !m_after_force;
            eg_c = c_req && !host_turn;
            eg_h = h_req && !eg_c;
        end
        g.cyc   = cyc;
        g.c     = eg_c;
        g.h     = eg_h;
        g.we    = eg_h ? h_we    : c_we;
        g.addr  = eg_h ? h_addr  : c_addr;
        g.wdata = eg_h ? h_wdata : c_wdata;
        g.be    = eg_h ? h_be    : c_be;
        gq.push_back(g);
        if (eg_c || eg_h) begin
            idx = g.addr[9:2];
            if (g.we) begin
                for (int b = 0; b < 4; b++)
                    if (g.be[b]) mmem[idx][8*b +: 8] = g.wdata[8*b +: 8];
            end else begin
                r.cyc  = cyc + 1;
                r.host = eg_h;
                r.data = mmem[idx];
                rq.push_back(r);
            end
        end
        if (eg_h) m_starve = 0;
        else if (h_req && m_starve < STARVE_LIMIT) m_starve++;
        nf = 1'b0;
        if (m_locked) begin
            if (!h_lock) m_locked = 1'b0;
            else if (m_lock_cycles == MAX_LOCK - 1) begin
                m_locked = 1'b0;
                nf = 1'b1;
            end else m_lock_cycles++;
        end else if (eg_h && h_lock) begin
            m_locked      = 1'b1;
            m_lock_cycles = 0;
        end
        m_after_force = nf;
        last_c = eg_c;
        last_h = eg_h;
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        c_req = req; c_we = we; c_addr = addr; c_wdata = wdata; c_be = be;
    endtask

    task automatic set_h(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input bit lock);
        h_req = req; h_we = we; h_addr = addr; h_wdata = wdata; h_be = be; h_lock = lock;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [7:0] idx;
        idx = 8'($urandom_range(8'h40, 8'h4F));
        return {22'h0, idx, 2'b00};
    endfunction

    // Monitor: compares DUT outputs with the scoreboard queues
    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            g = gq.pop_front();
            chk("c_gnt", {31'h0, c_gnt}, {31'h0, g.c});
            chk("h_gnt", {31'h0, h_gnt}, {31'h0, g.h});
            chk("dmem_req", {31'h0, dmem_req}, {31'h0, g.c | g.h});
            if (g.c || g.h) begin
                chk("dmem_we", {31'h0, dmem_we}, {31'h0, g.we});
                chk("dmem_addr", dmem_addr, g.addr);
                if (g.we) begin
                    chk("dmem_wdata", dmem_wdata, g.wdata);
                    chk("dmem_be", {28'h0, dmem_be}, {28'h0, g.be});
                end
            end
        end
        if (c_rvalid || h_rvalid) begin
            tests++;
            if (c_rvalid && h_rvalid) begin
                fails++;
                $display("FAIL rvalid_both at cyc %0d: c_rvalid=1 h_rvalid=1 expected one", cyc);
            end else if (rq.size() == 0) begin
                fails++;
                $display("FAIL rvalid_spurious at cyc %0d: c_rvalid=%0b h_rvalid=%0b expected none",
                         cyc, c_rvalid, h_rvalid);
            end else begin
                r = rq.pop_front();
                chk("rvalid_cycle", cyc, r.cyc);
                chk("rvalid_owner", {31'h0, h_rvalid}, {31'h0, r.host});
                chk("rdata", h_rvalid ? h_rdata : c_rdata, r.data);
            end
        end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
            r = rq.pop_front();
            tests++;
            fails++;
            $display("FAIL rvalid_missing at cyc %0d: no rvalid, expected host=%0b data %h",
                     cyc, r.host, r.data);
        end
    end

    initial begin
        bit c_busy, h_busy;
        rstn = 1'b0;
        set_c(0, 0, 32'h0, 32'h0, 4'h0);
        set_h(0, 0, 32'h0, 32'h0, 4'h0, 0);
        for (int i = 0; i < 256; i++) begin
            ram[i]  = 32'hA500_0000 | i;
            mmem[i] = 32'hA500_0000 | i;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_c_rvalid", {31'h0, c_rvalid}, 32'h0);
        chk("reset_h_rvalid", {31'h0, h_rvalid}, 32'h0);
        chk("reset_dmem_req", {31'h0, dmem_req}, 32'h0);
        rstn = 1'b1;

        // Core-only read of word 0x41
        set_c(1, 0, 32'h104, 32'h0, 4'hF);
        cycle();
        set_c(0, 0, 32'h0, 32'h0, 4'h0);
        cycle();
        cycle();

        // Host write then core read of the same word
        set_h(1, 1, 32'h180, 32'hDEADBEEF, 4'hF, 0);
        cycle();
        set_h(0, 0, 32'h0, 32'h0, 4'h0, 0);
        set_c(1, 0, 32'h180, 32'h0, 4'hF);
        cycle();
        set_c(0, 0, 32'h0, 32'h0, 4'h0);
        cycle();
        cycle();

        // Continuous contention: starvation guard pattern
        set_c(1, 0, 32'h104, 32'h0, 4'hF);
        set_h(1, 0, 32'h180, 32'h0, 4'hF, 0);
        repeat (14) cycle();
        set_c(0, 0, 32'h0, 32'h0, 4'h0);
        set_h(0, 0, 32'h0, 32'h0, 4'h0, 0);
        cycle();

        // Host lock for a few beats against a requesting core
        set_c(1, 0, 32'h104, 32'h0, 4'hF);
        set_h(1, 1, 32'h108, 32'h1111_0000, 4'h3, 1);
        for (int i = 0; i < 10 && !last_h; i++) cycle();
        repeat (2) cycle();
        h_lock = 1'b0;
        cycle();
        h_req = 1'b0;
        repeat (3) cycle();

        // Lock held past the limit: forced release
        set_h(1, 0, 32'h10C, 32'h0, 4'hF, 1);
        repeat (30) cycle();
        set_c(0, 0, 32'h0, 32'h0, 4'h0);
        set_h(0, 0, 32'h0, 32'h0, 4'h0, 0);
        cycle();

        // Reset in the cycle after a read acceptance
        set_c(1, 0, 32'h104, 32'h0, 4'hF);
        cycle();
        set_c(0, 0, 32'h0, 32'h0, 4'h0);
        rstn = 1'b0;
        model_reset();
        #1;
        chk("midreset_c_rvalid", {31'h0, c_rvalid}, 32'h0);
        chk("midreset_h_rvalid", {31'h0, h_rvalid}, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) cycle();

        // Randomised traffic
        c_busy = 1'b0;
        h_busy = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!c_busy && $urandom_range(0, 3) != 0) begin
                c_busy = 1'b1;
                set_c(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom));
            end
            if (!h_busy && $urandom_range(0, 2) == 0) begin
                h_busy = 1'b1;
                set_h(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom), 0);
            end
            c_req  = c_busy;
            h_req  = h_busy;
            h_lock = (n < 1500) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 19) < 19);
            cycle();
            if (last_c) c_busy = 1'b0;
            if (last_h) h_busy = 1'b0;
        end
        set_c(0, 0, 32'h0, 32'h0, 4'h0);
        set_h(0, 0, 32'h0, 32'h0, 4'h0, 0);
        repeat (3) cycle();
        chk("rq_drained", rq.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
